octal_display_scanner: RTL and testbench

Time-multiplexed driver for the board's eight-digit, common-anode seven-segment display. It sits downstream of the front panel. It takes two 12-bit PDP-8 words plus per-digit decimal-point, blank and blink masks, and shows each word as four octal digits. It also drives the active-low `an`, `seg` and `dp` pins, and latches its inputs once per frame so the display never shows a half-updated value.

---
 rtl/octal_display_scanner_if.sv | 36 +++
 rtl/octal_display_scanner.sv | 125 ++++++++++++
 tb/tb_octal_display_scanner.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/octal_display_scanner_if.sv
// Display-scanner bus: the front-panel words and masks in, the seven-segment pins and frame strobe out.
interface octal_display_scanner_if;
    logic [11:0] left_word;
    logic [11:0] right_word;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output left_word,
        output right_word,
        output dp_mask,
        output blank_mask,
        output blink_mask,
        input  an,
        input  seg,
        input  dp,
        input  frame_done
    );

    modport slave (
        input  left_word,
        input  right_word,
        input  dp_mask,
        input  blank_mask,
        input  blink_mask,
        output an,
        output seg,
        output dp,
        output frame_done
    );
endinterface

// File: rtl/octal_display_scanner.sv
// Eight-digit common-anode seven-segment scanner showing two 12-bit words as octal,
// with per-digit decimal point, blank and blink masks latched once per frame.
module octal_display_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  resetN,
    octal_display_scanner_if.slave disp
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [11:0] left_word;
        logic [11:0] right_word;
        logic [7:0]  dp_mask;
        logic [7:0]  blank_mask;
        logic [7:0]  blink_mask;
    } shadow_t;

    // Active-low segment pattern (seg[0]=a .. seg[6]=g) for one octal digit.
    function automatic logic [6:0] seg_decode(input logic [2:0] value);
        logic [6:0] code;
        code = 7'h7F;
        case (value)
            3'd0: code = 7'b1000000;
            3'd1: code = 7'b1111001;
            3'd2: code = 7'b0100100;
            3'd3: code = 7'b0110000;
            3'd4: code = 7'b0011001;
            3'd5: code = 7'b0010010;
            3'd6: code = 7'b0000010;
            3'd7: code = 7'b1111000;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    shadow_t          shadow_q, shadow_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             blink_phase_q, blink_phase_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             step_c;
    logic             wrap_c;
    logic [23:0]      digits_c;
    logic [2:0]       nib_c;
    logic             dark_c;

    // Scan timing, frame-boundary latch and registered pin values for the current digit.
    always_comb begin
        step_c        = (pre_q == PRE_LAST);
        wrap_c        = step_c && (idx_q == 3'd7);
        pre_d         = step_c ? '0 : pre_q + PRE_W'(1);
        idx_d         = step_c ? idx_q + 3'd1 : idx_q;
        shadow_d      = shadow_q;
        frm_d         = frm_q;
        blink_phase_d = blink_phase_q;

        if (wrap_c) begin
            shadow_d.left_word  = disp.left_word;
            shadow_d.right_word = disp.right_word;
            shadow_d.dp_mask    = disp.dp_mask;
            shadow_d.blank_mask = disp.blank_mask;
            shadow_d.blink_mask = disp.blink_mask;
            if (frm_q == FRM_LAST) begin
                frm_d         = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end

        // Digits 0..3 come from the right word, 4..7 from the left, three bits each.
        digits_c = {shadow_q.left_word, shadow_q.right_word};
        nib_c    = digits_c[5'(idx_q) * 5'd3 +: 3];
        dark_c   = shadow_q.blank_mask[idx_q]
                 | (shadow_q.blink_mask[idx_q] & blink_phase_q);

        // A dark digit keeps its anode low so every digit gets the same duty cycle.
        an_d         = ~(8'd1 << idx_q);
        seg_d        = dark_c ? 7'h7F : seg_decode(nib_c);
        dp_d         = dark_c ? 1'b1 : ~shadow_q.dp_mask[idx_q];
        frame_done_d = wrap_c;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            pre_q         <= '0;
            idx_q         <= 3'd0;
            shadow_q      <= '0;
            frm_q         <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            frm_q         <= frm_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_octal_display_scanner.sv
// Bench for octal_display_scanner: table vectors, hand-written corner sequences and a
// randomized run, all checked against a cycle-count arithmetic model of the display.
module tb_octal_display_scanner;

    localparam int unsigned R    = 4;
    localparam int unsigned BF   = 2;
    localparam int          FL   = 8 * R;
    localparam int          MAXF = 64;
    localparam logic [6:0]  SEG_TAB [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    typedef struct {
        logic [11:0] lw;
        logic [11:0] rw;
        logic [7:0]  dpm;
        logic [7:0]  blm;
        logic [7:0]  bkm;
    } snap_t;

    typedef struct {
        logic [11:0] rw;
        logic [11:0] lw;
        logic [7:0]  dpm;
        logic [7:0]  blm;
        logic [7:0]  bkm;
        int          d;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   e = 0;
    snap_t frames [MAXF];
    vec_t  vecs [14];

    octal_display_scanner_if bus();

    octal_display_scanner #(
        .REFRESH_DIV  (R),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .disp   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d after release)", name, act, exp_v, e);
        end
    endtask

    // One clock: capture inputs seen by the edge, advance, then compare against the model.
    task automatic tick();
        snap_t      cap;
        snap_t      sh;
        logic       rst_b;
        int         f;
        int         d;
        int         ph;
        logic [2:0] nib;
        logic       dark;
        logic [7:0] xa;
        logic [6:0] xs;
        logic       xd;
        logic       xf;
        cap.lw  = bus.left_word;
        cap.rw  = bus.right_word;
        cap.dpm = bus.dp_mask;
        cap.blm = bus.blank_mask;
        cap.bkm = bus.blink_mask;
        rst_b   = resetN;
        @(posedge clock);
        #1;
        if (!rst_b) begin
            e  = 0;
            xa = 8'hFF;
            xs = 7'h7F;
            xd = 1'b1;
            xf = 1'b0;
        end else begin
            e++;
            f  = (e - 1) / FL;
            d  = ((e - 1) / R) % 8;
            ph = (f / BF) % 2;
            if (f == 0) sh = '{lw: 12'd0, rw: 12'd0, dpm: 8'd0, blm: 8'd0, bkm: 8'd0};
            else        sh = frames[f % MAXF];
            if (e % FL == 0) frames[(e / FL) % MAXF] = cap;
            nib  = (d < 4) ? 3'(sh.rw >> (3 * d)) : 3'(sh.lw >> (3 * (d - 4)));
            dark = sh.blm[d] || (sh.bkm[d] && ph == 1);
            xa   = ~(8'd1 << d);
            xs   = dark ? 7'h7F : SEG_TAB[nib];
            xd   = dark ? 1'b1 : ~sh.dpm[d];
            xf   = (e % FL == 0);
        end
        check("model_an", 32'(bus.an), 32'(xa));
        check("model_seg", 32'(bus.seg), 32'(xs));
        check("model_dp", 32'(bus.dp), 32'(xd));
        check("model_frame_done", 32'(bus.frame_done), 32'(xf));
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (e < target && guard < 4 * FL * 8) begin
            tick();
            guard++;
        end
        check("run_until_target", 32'(e), 32'(target));
    endtask

    task automatic set_inputs(input logic [11:0] rw, input logic [11:0] lw,
                              input logic [7:0] dpm, input logic [7:0] blm, input logic [7:0] bkm);
        bus.right_word = rw;
        bus.left_word  = lw;
        bus.dp_mask    = dpm;
        bus.blank_mask = blm;
        bus.blink_mask = bkm;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        int seen;
        logic expect_dark;

        vecs[0]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 0, 8'hFE, 7'b0011001, 1'b1};
        vecs[1]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 1, 8'hFD, 7'b0110000, 1'b1};
        vecs[2]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 2, 8'hFB, 7'b0100100, 1'b1};
        vecs[3]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 3, 8'hF7, 7'b1111001, 1'b1};
        vecs[4]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 4, 8'hEF, 7'b1000000, 1'b1};
        vecs[5]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 5, 8'hDF, 7'b1111000, 1'b1};
        vecs[6]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 6, 8'hBF, 7'b0000010, 1'b1};
        vecs[7]  = '{12'o1234, 12'o5670, 8'h00, 8'h00, 8'h00, 7, 8'h7F, 7'b0010010, 1'b1};
        vecs[8]  = '{12'o0000, 12'o0000, 8'h81, 8'h02, 8'h00, 0, 8'hFE, 7'b1000000, 1'b0};
        vecs[9]  = '{12'o0000, 12'o0000, 8'h81, 8'h02, 8'h00, 1, 8'hFD, 7'h7F,      1'b1};
        vecs[10] = '{12'o0000, 12'o0000, 8'h81, 8'h02, 8'h00, 7, 8'h7F, 7'b1000000, 1'b0};
        vecs[11] = '{12'o0000, 12'o0000, 8'h81, 8'h02, 8'h00, 2, 8'hFB, 7'b1000000, 1'b1};
        vecs[12] = '{12'o0000, 12'o1234, 8'h00, 8'h00, 8'h10, 4, 8'hEF, 7'b0011001, 1'b1};
        vecs[13] = '{12'o7777, 12'o0000, 8'hFF, 8'hFF, 8'h00, 3, 8'hF7, 7'h7F,      1'b1};

        set_inputs(12'd0, 12'd0, 8'd0, 8'd0, 8'd0);

        // Reset held for three cycles, then the first digit right after release.
        resetN = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("reset_an", 32'(bus.an), 32'h0FF);
        check("reset_seg", 32'(bus.seg), 32'h7F);
        check("reset_dp", 32'(bus.dp), 32'd1);
        resetN = 1'b1;
        tick();
        check("release_an", 32'(bus.an), 32'h0FE);
        check("release_seg", 32'(bus.seg), 32'(7'b1000000));
        check("release_dp", 32'(bus.dp), 32'd1);

        // Table: inputs applied before the first wrap, digit inspected in frame 1.
        for (int v = 0; v < 14; v++) begin
            do_reset();
            set_inputs(vecs[v].rw, vecs[v].lw, vecs[v].dpm, vecs[v].blm, vecs[v].bkm);
            run_until(FL + R * vecs[v].d + 1);
            check($sformatf("vec%0d_an", v), 32'(bus.an), 32'(vecs[v].an));
            check($sformatf("vec%0d_seg", v), 32'(bus.seg), 32'(vecs[v].seg));
            check($sformatf("vec%0d_dp", v), 32'(bus.dp), 32'(vecs[v].dp));
        end

        // Tear-free latch: a mid-frame change waits for the next frame boundary.
        do_reset();
        set_inputs(12'o0000, 12'o0000, 8'd0, 8'd0, 8'd0);
        run_until(FL + 2 * R);
        bus.right_word = 12'o7777;
        run_until(FL + 3 * R + 1);
        check("tear_old_digit3", 32'(bus.seg), 32'(7'b1000000));
        seen = 0;
        for (int i = 0; i < 2 * FL && seen == 0; i++) begin
            tick();
            if (bus.frame_done) seen = 1;
        end
        check("tear_frame_done_seen", 32'(seen), 32'd1);
        tick();
        check("tear_new_an", 32'(bus.an), 32'h0FE);
        check("tear_new_seg", 32'(bus.seg), 32'(7'b1111000));

        // Blink: digit 4 lit in frame 1, dark in frames 2-3, lit again in frame 4.
        do_reset();
        set_inputs(12'o0000, 12'o0000, 8'd0, 8'd0, 8'h10);
        for (int f = 1; f <= 4; f++) begin
            expect_dark = (f == 2 || f == 3);
            run_until(FL * f + 3 * R + 1);
            check($sformatf("blink_f%0d_digit3", f), 32'(bus.seg), 32'(7'b1000000));
            run_until(FL * f + 4 * R + 1);
            check($sformatf("blink_f%0d_an4", f), 32'(bus.an), 32'h0EF);
            check($sformatf("blink_f%0d_digit4", f), 32'(bus.seg),
                  expect_dark ? 32'h7F : 32'(7'b1000000));
        end

        // Reset while digit 5 is showing discards the latched words.
        do_reset();
        set_inputs(12'o7777, 12'o7777, 8'hFF, 8'd0, 8'd0);
        run_until(FL + 5 * R + 1);
        check("midreset_pre_an", 32'(bus.an), 32'h0DF);
        resetN = 1'b0;
        tick();
        check("midreset_an", 32'(bus.an), 32'h0FF);
        check("midreset_seg", 32'(bus.seg), 32'h7F);
        check("midreset_dp", 32'(bus.dp), 32'd1);
        check("midreset_fd", 32'(bus.frame_done), 32'd0);
        resetN = 1'b1;
        tick();
        check("midreset_rel_an", 32'(bus.an), 32'h0FE);
        check("midreset_rel_seg", 32'(bus.seg), 32'(7'b1000000));
        check("midreset_rel_dp", 32'(bus.dp), 32'd1);

        // Randomized inputs and occasional resets, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.right_word = 12'($urandom);
            if ($urandom_range(0, 19) == 0) bus.left_word  = 12'($urandom);
            if ($urandom_range(0, 29) == 0) bus.dp_mask    = 8'($urandom);
            if ($urandom_range(0, 29) == 0) bus.blank_mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 29) == 0) bus.blink_mask = 8'($urandom);
            resetN = ($urandom_range(0, 599) != 0);
            tick();
        end
        resetN = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
